// File: rtl/instr_encoder.sv
// MIPS instruction encoder with a small output word FIFO.
// Optional macro ENC_ILLEGAL_NOP_EN: illegal mnemonics enqueue a nop word.
module instr_encoder #(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [15:0]      in_imm,
  input  logic [25:0]      in_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] level,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      word;
  logic             legal;
  logic             acc;
  logic             push;
  logic             pop;

  function automatic logic [31:0] r_word(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [4:0] sh,
    input logic [5:0] fn
  );
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

  // Combinational encode of the presented request
  always_comb begin
    word  = 32'h0;
    legal = 1'b1;
    case (in_op)
      5'd0:  word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h20);
      5'd1:  word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h22);
      5'd2:  word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h24);
      5'd3:  word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h25);
      5'd4:  word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h26);
      5'd5:  word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h27);
      5'd6:  word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2A);
      5'd7:  word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2B);
      5'd8:  word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h00);
      5'd9:  word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h02);
      5'd10: word = r_word(in_rs, 5'd0, 5'd0, 5'd0, 6'h08);
      5'd11: word = i_word(6'h08, in_rs, in_rt, in_imm);
      5'd12: word = i_word(6'h0C, in_rs, in_rt, in_imm);
      5'd13: word = i_word(6'h0D, in_rs, in_rt, in_imm);
      5'd14: word = i_word(6'h0E, in_rs, in_rt, in_imm);
      5'd15: word = i_word(6'h0A, in_rs, in_rt, in_imm);
      5'd16: word = i_word(6'h0B, in_rs, in_rt, in_imm);
      5'd17: word = i_word(6'h0F, 5'd0, in_rt, in_imm);
      5'd18: word = i_word(6'h23, in_rs, in_rt, in_imm);
      5'd19: word = i_word(6'h2B, in_rs, in_rt, in_imm);
      5'd20: word = i_word(6'h04, in_rs, in_rt, in_imm);
      5'd21: word = i_word(6'h05, in_rs, in_rt, in_imm);
      5'd22: word = {6'h02, in_target};
      5'd23: word = {6'h03, in_target};
      default: legal = 1'b0;
    endcase
  end

  assign in_ready  = (cnt != CNT_W'(DEPTH)) & ~flush;
  assign acc       = in_valid & in_ready;
`ifdef ENC_ILLEGAL_NOP_EN
  assign push      = acc;
`else
  assign push      = acc & legal;
`endif
  assign out_valid = (cnt != '0);
  assign pop       = out_valid & out_ready & ~flush;
  assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;
  assign level     = cnt;

  // Word storage; no reset needed since reads are gated by out_valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  // Pointers, occupancy and the illegal-op pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      err <= acc & ~legal;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: random requests vs a table model.
// Honours ENC_ILLEGAL_NOP_EN when defined at compile time.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef ENC_ILLEGAL_NOP_EN
  localparam bit NOP_EN = 1'b1;
`else
  localparam bit NOP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [4:0] in_op = '0;
  logic [4:0] in_rs = '0;
  logic [4:0] in_rt = '0;
  logic [4:0] in_rd = '0;
  logic [4:0] in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [CNT_W-1:0] level;
  logic err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  bit err_exp = 1'b0;
  bit acc = 1'b0;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .level(level), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: {illegal, word} from the mnemonic tables
  function automatic logic [32:0] ref_enc(input int op, input int rs,
      input int rt, input int rd, input int sh, input int imm,
      input int tgt);
    int fn[11]  = '{32, 34, 36, 37, 38, 39, 42, 43, 0, 2, 8};
    int opc[11] = '{8, 12, 13, 14, 10, 11, 15, 35, 43, 4, 5};
    longint w;
    if (op < 11) begin
      if (op == 8 || op == 9) rs = 0;
      else sh = 0;
      if (op == 10) begin
        rt = 0;
        rd = 0;
      end
      w = longint'(rs) * 2097152 + longint'(rt) * 65536
        + longint'(rd) * 2048 + longint'(sh) * 64 + fn[op];
    end else if (op < 22) begin
      if (op == 17) rs = 0;
      w = longint'(opc[op-11]) * 67108864 + longint'(rs) * 2097152
        + longint'(rt) * 65536 + imm;
    end else if (op < 24) begin
      w = longint'(op - 20) * 67108864 + tgt;
    end else begin
      return {1'b1, 32'h0};
    end
    return {1'b0, w[31:0]};
  endfunction

  // Called at posedge+1 with inputs set; returns at next posedge+1
  task automatic step();
    logic [32:0] r;
    #1;
    chk("in_ready", 32'(in_ready),
        32'((exp_q.size() != DEPTH) && !flush));
    acc = in_valid && in_ready;
    r = ref_enc(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd),
                int'(in_shamt), int'(in_imm), int'(in_target));
    @(posedge clk);
    #1;
    if (flush) exp_q.delete();
    else if (acc && (!r[32] || NOP_EN)) exp_q.push_back(r[31:0]);
    err_exp = acc && r[32];
  endtask

  task automatic set_req(input int op, input int rs, input int rt,
      input int rd, input int sh, input int imm, input int tgt);
    in_valid  = 1'b1;
    in_op     = 5'(op);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_shamt  = 5'(sh);
    in_imm    = 16'(imm);
    in_target = 26'(tgt);
  endtask

  task automatic rand_req(input bit legal_only);
    int op;
    op = (legal_only || $urandom_range(7) != 0) ?
         int'($urandom_range(23)) : int'($urandom_range(31, 24));
    set_req(op, $urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("drain_level", 32'(level), 32'd0);
    out_ready = 1'b0;
  endtask

  // Spec vector: FIFO empty, out_ready low, word visible one cycle later
  task automatic direct(input string nm, input int op, input int rs,
      input int rt, input int rd, input int sh, input int imm,
      input int tgt, input logic [31:0] expw);
    set_req(op, rs, rt, rd, sh, imm, tgt);
    step();
    in_valid = 1'b0;
    chk(nm, out_instr, expw);
    chk({nm, "_lvl"}, 32'(level), 32'd1);
    drain();
  endtask

  // Monitor: compares the FIFO head and status against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("level", 32'(level), 32'(exp_q.size()));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("err", 32'(err), 32'(err_exp));
        chk("out_instr", out_instr,
            exp_q.size() != 0 ? exp_q[0] : 32'h0);
        if (out_valid && out_ready && !flush && exp_q.size() != 0)
          void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    direct("add", 0, 1, 2, 3, 0, 0, 0, 32'h00221820);
    direct("lw", 18, 29, 8, 0, 0, 4, 0, 32'h8FA80004);
    direct("lui", 17, 7, 1, 0, 0, 16'h1234, 0, 32'h3C011234);
    direct("sll", 8, 5, 3, 2, 4, 0, 0, 32'h00031100);
    direct("jal", 23, 0, 0, 0, 0, 0, 26'h0100000, 32'h0C100000);

    // Illegal op pulses err for exactly one cycle
    set_req(31, 1, 2, 3, 4, 5, 6);
    step();
    in_valid = 1'b0;
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_lvl", 32'(level), NOP_EN ? 32'd1 : 32'd0);
    step();
    chk("ill_err_low", 32'(err), 32'd0);
    drain();

    // Fill to full, then stream with pops across pointer wrap
    for (int i = 0; i < DEPTH; i++) begin
      rand_req(1'b1);
      step();
    end
    chk("full_lvl", 32'(level), DEPTH);
    rand_req(1'b1);
    step();
    chk("full_block", 32'(level), DEPTH);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rand_req(1'b1);
      step();
    end
    drain();

    // Async reset with three words queued
    for (int i = 0; i < 3; i++) begin
      rand_req(1'b1);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_lvl", 32'(level), 32'd3);
    reset = 1'b1;
    #1;
    chk("arst_lvl", 32'(level), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    err_exp = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Flush with a request present: nothing enqueued
    for (int i = 0; i < 2; i++) begin
      rand_req(1'b1);
      step();
    end
    rand_req(1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_lvl", 32'(level), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) != 0) rand_req(1'b0);
      else in_valid = 1'b0;
      out_ready = ($urandom_range(2) != 0);
      flush = ($urandom_range(19) == 0);
      step();
    end
    flush = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
